// File: rtl/q_8_8_arbiter.sv
// Round-robin arbiter that shares one q_8_8 Q8.8 unit between NUM_REQ clients.
// It captures the winner's operands, runs the start/rdy handshake and returns the result with a done pulse.
module q_8_8_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int W       = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*W-1:0] a_in,
  input  logic [NUM_REQ*W-1:0] b_in,
  output logic [NUM_REQ-1:0]   ack,
  output logic [NUM_REQ-1:0]   done,
  output logic [W-1:0]         result,
  output logic                 result_carry,
  output logic                 err,
  output logic                 busy,
  output logic                 q_start,
  output logic [W-1:0]         q_A,
  output logic [W-1:0]         q_B,
  input  logic [W-1:0]         q_C,
  input  logic                 q_carry,
  input  logic                 q_rdy
);

  localparam int PW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PW1 = PW + 1;
  localparam int CW  = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ISSUE     = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_RESP      = 3'd4;

  logic [2:0]         state_r;
  logic [PW-1:0]      rr_ptr_r;
  logic [PW-1:0]      gnt_r;
  logic [CW-1:0]      cnt_r;
  logic [NUM_REQ-1:0] ack_r;
  logic [NUM_REQ-1:0] done_r;
  logic [W-1:0]       result_r;
  logic               result_carry_r;
  logic               err_r;
  logic               q_start_r;
  logic [W-1:0]       q_a_r;
  logic [W-1:0]       q_b_r;

  logic               pick_valid_s;
  logic [PW-1:0]      pick_idx_s;
  logic [PW:0]        cand_s;
  logic               cnt_expired_s;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [PW-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v = {NUM_REQ{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] idx);
    logic [PW-1:0] n;
    if (idx == PW'(NUM_REQ - 1)) begin
      n = {PW{1'b0}};
    end else begin
      n = idx + PW'(1);
    end
    return n;
  endfunction

  assign cnt_expired_s = (cnt_r == CW'(TIMEOUT - 1));

  // Round-robin search: first set request at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    pick_valid_s = 1'b0;
    pick_idx_s   = {PW{1'b0}};
    cand_s       = {PW1{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_s = {1'b0, rr_ptr_r} + PW1'(i);
      if (cand_s >= PW1'(NUM_REQ)) begin
        cand_s = cand_s - PW1'(NUM_REQ);
      end else begin
        cand_s = cand_s;
      end
      if (!pick_valid_s && req[cand_s[PW-1:0]]) begin
        pick_valid_s = 1'b1;
        pick_idx_s   = cand_s[PW-1:0];
      end else begin
        pick_valid_s = pick_valid_s;
      end
    end
  end

  // Arbitration FSM with registered handshake, response and timeout bookkeeping.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_r        <= S_IDLE;
      rr_ptr_r       <= {PW{1'b0}};
      gnt_r          <= {PW{1'b0}};
      cnt_r          <= {CW{1'b0}};
      ack_r          <= {NUM_REQ{1'b0}};
      done_r         <= {NUM_REQ{1'b0}};
      result_r       <= {W{1'b0}};
      result_carry_r <= 1'b0;
      err_r          <= 1'b0;
      q_start_r      <= 1'b0;
      q_a_r          <= {W{1'b0}};
      q_b_r          <= {W{1'b0}};
    end else begin
      ack_r     <= {NUM_REQ{1'b0}};
      done_r    <= {NUM_REQ{1'b0}};
      q_start_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (pick_valid_s) begin
            gnt_r   <= pick_idx_s;
            q_a_r   <= a_in[int'(pick_idx_s)*W +: W];
            q_b_r   <= b_in[int'(pick_idx_s)*W +: W];
            ack_r   <= onehot(pick_idx_s);
            state_r <= S_ISSUE;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_ISSUE: begin
          // Start lands one cycle after ack so the two pulses never overlap.
          q_start_r <= 1'b1;
          cnt_r     <= {CW{1'b0}};
          state_r   <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (!q_rdy) begin
            cnt_r   <= {CW{1'b0}};
            state_r <= S_WAIT_DONE;
          end else if (cnt_expired_s) begin
            result_r       <= {W{1'b0}};
            result_carry_r <= 1'b0;
            err_r          <= 1'b1;
            done_r         <= onehot(gnt_r);
            state_r        <= S_RESP;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        S_WAIT_DONE: begin
          if (q_rdy) begin
            result_r       <= q_C;
            result_carry_r <= q_carry;
            err_r          <= 1'b0;
            done_r         <= onehot(gnt_r);
            state_r        <= S_RESP;
          end else if (cnt_expired_s) begin
            result_r       <= {W{1'b0}};
            result_carry_r <= 1'b0;
            err_r          <= 1'b1;
            done_r         <= onehot(gnt_r);
            state_r        <= S_RESP;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        S_RESP: begin
          rr_ptr_r <= next_ptr(gnt_r);
          state_r  <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign ack          = ack_r;
  assign done         = done_r;
  assign result       = result_r;
  assign result_carry = result_carry_r;
  assign err          = err_r;
  assign busy         = (state_r != S_IDLE);
  assign q_start      = q_start_r;
  assign q_A          = q_a_r;
  assign q_B          = q_b_r;

endmodule

// File: tb/tb_q_8_8_arbiter.sv
// Directed + randomized bench for q_8_8_arbiter with a behavioural q_8_8 stand-in.
module tb_q_8_8_arbiter;

  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst_b = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] a_in = '0;
  logic [N*W-1:0] b_in = '0;
  logic [N-1:0]   ack, done;
  logic [W-1:0]   result, q_A, q_B;
  logic           result_carry, err, busy, q_start;

  logic [W-1:0]   q_c_m;
  logic           q_carry_m;
  logic           q_rdy_m;
  int             unit_cnt;
  bit             ignore_start = 1'b0;

  int tests = 0;
  int fails = 0;
  int ptr_m = 0;

  q_8_8_arbiter #(.NUM_REQ(N), .W(W), .TIMEOUT(64)) dut (
    .clk(clk), .rst_b(rst_b), .req(req), .a_in(a_in), .b_in(b_in),
    .ack(ack), .done(done), .result(result), .result_carry(result_carry),
    .err(err), .busy(busy), .q_start(q_start), .q_A(q_A), .q_B(q_B),
    .q_C(q_c_m), .q_carry(q_carry_m), .q_rdy(q_rdy_m)
  );

  always #5 clk = ~clk;

  // q_8_8 stand-in: rdy low one cycle after start, for three cycles; C = A^B, carry = A[15]&B[15].
  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      q_rdy_m   <= 1'b1;
      q_c_m     <= '0;
      q_carry_m <= 1'b0;
      unit_cnt  <= 0;
    end else if (q_start && !ignore_start) begin
      q_c_m     <= q_A ^ q_B;
      q_carry_m <= q_A[15] & q_B[15];
      q_rdy_m   <= 1'b0;
      unit_cnt  <= 3;
    end else if (unit_cnt > 0) begin
      unit_cnt <= unit_cnt - 1;
      if (unit_cnt == 1) q_rdy_m <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] m, input int p);
    for (int i = 0; i < N; i++) begin
      int k;
      k = (p + i) % N;
      if (m[k]) return k;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst_b = 1'b0;
    req   = '0;
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_carry", 32'(result_carry), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_qstart", 32'(q_start), 32'd0);
    chk("rst_qA", 32'(q_A), 32'd0);
    chk("rst_qB", 32'(q_B), 32'd0);
    rst_b = 1'b1;
    ptr_m = 0;
    @(negedge clk);
  endtask

  task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    a_in[i*W +: W] = a;
    b_in[i*W +: W] = b;
  endtask

  // Follow one grant for requester idx from ack to done; called at a negedge.
  task automatic serve(input int idx, input logic [W-1:0] ea, input logic [W-1:0] eb,
                       input logic [W-1:0] eres, input logic ecar, input logic eerr,
                       input int bound, input bit mangle);
    int n;
    n = 0;
    while (ack == '0 && n < 20) begin @(negedge clk); n++; end
    chk("ack", 32'(ack), 32'd1 << idx);
    chk("ack_qA", 32'(q_A), 32'(ea));
    chk("ack_qB", 32'(q_B), 32'(eb));
    chk("ack_busy", 32'(busy), 32'd1);
    if (mangle) a_in[idx*W +: W] = 16'h0001;
    n = 0;
    while (q_start == 1'b0 && n < 20) begin @(negedge clk); n++; end
    chk("qstart", 32'(q_start), 32'd1);
    chk("qstart_noack", 32'(ack), 32'd0);
    chk("qstart_qA", 32'(q_A), 32'(ea));
    n = 0;
    while (done == '0 && n < bound) begin @(negedge clk); n++; end
    chk("done", 32'(done), 32'd1 << idx);
    chk("result", 32'(result), 32'(eres));
    chk("carry", 32'(result_carry), 32'(ecar));
    chk("err", 32'(err), 32'(eerr));
    chk("done_noack", 32'(ack | {N{q_start}}), 32'd0);
    req[idx] = 1'b0;
    ptr_m = (idx + 1) % N;
  endtask

  initial begin
    logic [W-1:0] ra [N];
    logic [W-1:0] rb [N];
    logic [N-1:0] pend;
    int g, n;

    do_reset();

    // Single request, operand changed right after ack.
    set_ops(0, 16'h5555, 16'h1234);
    req[0] = 1'b1;
    serve(0, 16'h5555, 16'h1234, 16'h4761, 1'b0, 1'b0, 20, 1'b1);

    // All four together after reset.
    do_reset();
    set_ops(0, 16'hFFFF, 16'h8000);
    set_ops(1, 16'h0000, 16'hFFFF);
    set_ops(2, 16'hAAA5, 16'h5500);
    set_ops(3, 16'h0FFF, 16'h7FFF);
    req = 4'b1111;
    serve(0, 16'hFFFF, 16'h8000, 16'h7FFF, 1'b1, 1'b0, 20, 1'b0);
    serve(1, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 20, 1'b0);
    serve(2, 16'hAAA5, 16'h5500, 16'hFFA5, 1'b0, 1'b0, 20, 1'b0);
    serve(3, 16'h0FFF, 16'h7FFF, 16'h7000, 1'b0, 1'b0, 20, 1'b0);

    // Wrap: pointer is back at 0, so 1 wins over 3.
    set_ops(1, 16'h1111, 16'h2222);
    set_ops(3, 16'h8001, 16'h8000);
    req = 4'b1010;
    serve(1, 16'h1111, 16'h2222, 16'h3333, 1'b0, 1'b0, 20, 1'b0);
    serve(3, 16'h8001, 16'h8000, 16'h0001, 1'b1, 1'b0, 20, 1'b0);

    // Unit never responds: timeout then a normal request.
    ignore_start = 1'b1;
    set_ops(2, 16'h1234, 16'h4321);
    req[2] = 1'b1;
    serve(2, 16'h1234, 16'h4321, 16'h0000, 1'b0, 1'b1, 200, 1'b0);
    ignore_start = 1'b0;
    set_ops(0, 16'hC0DE, 16'h8BAD);
    req[0] = 1'b1;
    serve(0, 16'hC0DE, 16'h8BAD, 16'h4B73, 1'b1, 1'b0, 20, 1'b0);

    // Randomized batches checked against the round-robin reference.
    for (int it = 0; it < 20; it++) begin
      pend = 4'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) begin
        ra[i] = 16'($urandom);
        rb[i] = 16'($urandom);
        set_ops(i, ra[i], rb[i]);
      end
      req = pend;
      while (pend != '0) begin
        g = pick(pend, ptr_m);
        serve(g, ra[g], rb[g], ra[g] ^ rb[g], ra[g][15] & rb[g][15], 1'b0, 20, 1'b0);
        pend[g] = 1'b0;
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Reset during WAIT_DONE abandons the operation.
    set_ops(0, 16'h3211, 16'hE4AC);
    req[0] = 1'b1;
    n = 0;
    while (ack == '0 && n < 20) begin @(negedge clk); n++; end
    n = 0;
    while (q_rdy_m == 1'b1 && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    rst_b = 1'b0;
    #1;
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_result", 32'(result), 32'd0);
    chk("midrst_err", 32'(err), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_qA", 32'(q_A), 32'd0);
    @(negedge clk);
    rst_b = 1'b1;
    ptr_m = 0;
    serve(0, 16'h3211, 16'hE4AC, 16'hD6BD, 1'b0, 1'b0, 20, 1'b0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/q_8_8_arbiter.md
Name: q_8_8_arbiter

Overview:
- Shares one q_8_8 Q8.8 compare/arithmetic unit between NUM_REQ requesters.
- Arbitration is round-robin. The block registers the granted requester's operands and drives the unit's start/A/B handshake.
- It tracks the unit's rdy, returns C/carry to the winner with a one-cycle done pulse, and flags a timeout if the unit stalls.
- Sits between client FSMs and the single q_8_8 instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- W, 16, operand/result width (Q8.8).
- TIMEOUT, 64, max cycles allowed in either wait state before the operation is aborted.

Ports:
- clk  input  1  system clock, rising edge.
- rst_b  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  per-requester request level; held until that requester's done.
- a_in  input  NUM_REQ*W  flattened A operands; requester i occupies bits [i*W +: W].
- b_in  input  NUM_REQ*W  flattened B operands, same packing as a_in.
- ack  output  NUM_REQ  one-hot, one-cycle pulse: operands of requester i captured.
- done  output  NUM_REQ  one-hot, one-cycle pulse: result valid for requester i.
- result  output  W  result bus; valid when any done bit is high.
- result_carry  output  1  carry from the unit; valid with done.
- err  output  1  high with done when the operation timed out.
- busy  output  1  high in every state except IDLE.
- q_start  output  1  start to q_8_8.
- q_A  output  W  A operand to q_8_8.
- q_B  output  W  B operand to q_8_8.
- q_C  input  W  C result from q_8_8.
- q_carry  input  1  carry from q_8_8.
- q_rdy  input  1  q_8_8 rdy: high when idle/result valid, low while computing.

Behaviour:
- Reset (async, rst_b=0):
  - FSM goes to IDLE; rr_ptr=0.
  - Outputs: ack=0, done=0, result=0, result_carry=0, err=0, busy=0, q_start=0, q_A=0, q_B=0.
  - Timeout counter cleared. Reset mid-operation abandons the transaction with no done pulse.
- IDLE:
  - If req!=0, pick the first set bit searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - Latch that index as gnt. Register a_in/b_in slices into q_A/q_B. Pulse ack[gnt]. Go to ISSUE.
  - Total latency from req high in IDLE to ack is 1 cycle.
- ISSUE:
  - Drive q_start=1 for exactly one cycle. Clear the timeout counter. Go to WAIT_BUSY.
- WAIT_BUSY:
  - Wait for q_rdy=0 (unit accepted the start).
  - If q_rdy=0, go to WAIT_DONE and clear the counter.
- WAIT_DONE:
  - Wait for q_rdy=1.
  - On q_rdy=1, capture result<=q_C and result_carry<=q_carry, set err=0, go to RESP.
- Timeout:
  - In WAIT_BUSY or WAIT_DONE, the counter increments each cycle.
  - When the counter reaches TIMEOUT-1 without the exit condition, set result=0, result_carry=0, err=1, and go to RESP.
- RESP:
  - Pulse done[gnt]; result/result_carry/err are valid this cycle.
  - Set rr_ptr<=(gnt+1) mod NUM_REQ (wrap-around). Return to IDLE.
  - result/result_carry/err hold until the next RESP or reset.
- q_A/q_B are held stable from capture through WAIT_DONE.
- Changes to a_in/b_in after ack are ignored.
- Requests arriving while busy wait; they are evaluated only in IDLE.
- A requester dropping req before done does not cancel the operation; done still fires.
- Minimum back-to-back spacing per grant: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP = 5 cycles when the unit responds immediately.
- Simultaneous requests are resolved strictly by rr_ptr priority. No requester waits more than NUM_REQ-1 grants.
- ack, done, and q_start are never asserted in the same cycle.

Test Plan:
- Bench q_8_8 model: rdy drops 1 cycle after start, rises 3 cycles later; C=A^B, carry=A[15]&B[15].
- Single request: req[0] with A=16'h5555, B=16'h1234 -> ack[0] 1 cycle after req; one q_start pulse with q_A=5555, q_B=1234; done[0] with result=16'h4761, carry=0, err=0.
- All four requesters request together after reset:
  - Operands: A=16'hFFFF/B=16'h8000 for req 0; A=16'h0000/B=16'hFFFF for 1; A=16'hAAA5/B=16'h5500 for 2; A=16'h0FFF/B=16'h7FFF for 3.
  - Required: done order 0,1,2,3; results FFFF^8000=7FFF with carry=1, then FFFF, FFA5, 7000.
- Round-robin wrap: after grant to 3, assert req[3] and req[1] together -> req[1] granted first, because rr_ptr=0 searches 0,1,... .
- Timeout: model holds q_rdy=1 and ignores start, with TIMEOUT=64 -> done pulses after WAIT_BUSY expires with err=1, result=0; next request is served normally.
- Reset mid-operation: A=16'h3211, B=16'hE4AC; assert rst_b=0 during WAIT_DONE -> outputs zero immediately, no done; after release, the re-asserted req is granted and completes with result=16'hD6BD.
- Operand stability: change a_in[0] to 16'h0001 in the cycle after ack -> q_A unchanged; result uses the original value.
